// File: rtl/lfsr_mon_pkg.sv
// Shared types and default sizing for the LFSR period monitor.
package lfsr_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PERIOD_W   = 8;
    localparam int DEF_MAX_PERIOD = 255;

endpackage

// File: rtl/lfsr_mon_cnt.sv
// Sample counter: clear, enable, terminal count at MAX_PERIOD.
// Clear with enable loads 1, so the seed sample is counted in the same edge.
module lfsr_mon_cnt
    import lfsr_mon_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clr,
    input  logic                i_en,
    output logic [PERIOD_W-1:0] o_cnt,
    output logic                o_tc
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_en ? PERIOD_W'(1) : '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == PERIOD_W'(MAX_PERIOD));

endmodule

// File: rtl/lfsr_period_monitor.sv
// Captures a seed, counts valid samples until it recurs, flags zero/stuck/timeout.
// Registered outputs; period_valid rises on the edge that samples the seed repeat.
module lfsr_period_monitor
    import lfsr_mon_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_restart,
    input  logic                i_in_valid,
    input  logic [WIDTH-1:0]    i_in_data,
    output logic                o_busy,
    output logic                o_period_valid,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_zero_err,
    output logic                o_stuck_err,
    output logic                o_timeout_err
);

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_seed, w_seed_nxt;
    logic [WIDTH-1:0]    r_prev, w_prev_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_pv, w_pv_nxt;
    logic [PERIOD_W-1:0] r_period, w_period_nxt;
    logic                r_zero, w_zero_nxt;
    logic                r_stuck, w_stuck_nxt;
    logic                r_tout, w_tout_nxt;

    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic [PERIOD_W-1:0] w_cnt;
    logic                w_cnt_tc;

    lfsr_mon_cnt #(
        .PERIOD_W   (PERIOD_W),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_cnt   (w_cnt),
        .o_tc    (w_cnt_tc)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_seed   <= '0;
            r_prev   <= '0;
            r_busy   <= 1'b0;
            r_pv     <= 1'b0;
            r_period <= '0;
            r_zero   <= 1'b0;
            r_stuck  <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_seed   <= w_seed_nxt;
            r_prev   <= w_prev_nxt;
            r_busy   <= w_busy_nxt;
            r_pv     <= w_pv_nxt;
            r_period <= w_period_nxt;
            r_zero   <= w_zero_nxt;
            r_stuck  <= w_stuck_nxt;
            r_tout   <= w_tout_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_seed_nxt   = r_seed;
        w_prev_nxt   = r_prev;
        w_busy_nxt   = r_busy;
        w_pv_nxt     = r_pv;
        w_period_nxt = r_period;
        w_zero_nxt   = r_zero;
        w_stuck_nxt  = r_stuck;
        w_tout_nxt   = r_tout;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;

        if (i_restart) begin
            w_state_nxt  = ST_IDLE;
            w_seed_nxt   = '0;
            w_prev_nxt   = '0;
            w_busy_nxt   = 1'b0;
            w_pv_nxt     = 1'b0;
            w_period_nxt = '0;
            w_zero_nxt   = 1'b0;
            w_stuck_nxt  = 1'b0;
            w_tout_nxt   = 1'b0;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        if (i_in_data == '0) begin
                            w_zero_nxt  = 1'b1;
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_seed_nxt  = i_in_data;
                            w_prev_nxt  = i_in_data;
                            w_cnt_clr   = 1'b1;
                            w_cnt_en    = 1'b1;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = ST_MEASURE;
                        end
                    end
                end
                ST_MEASURE: begin
                    // A period-1 stream hits the stuck check before the seed match.
                    if (i_in_valid) begin
                        if (i_in_data == '0) begin
                            w_zero_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_ERROR;
                        end else if (i_in_data == r_prev) begin
                            w_stuck_nxt = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_ERROR;
                        end else if (i_in_data == r_seed) begin
                            w_period_nxt = w_cnt;
                            w_pv_nxt     = 1'b1;
                            w_busy_nxt   = 1'b0;
                            w_state_nxt  = ST_DONE;
                        end else if (w_cnt_tc) begin
                            w_tout_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_cnt_en   = 1'b1;
                            w_prev_nxt = i_in_data;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_period_valid = r_pv;
    assign o_period       = r_period;
    assign o_zero_err     = r_zero;
    assign o_stuck_err    = r_stuck;
    assign o_timeout_err  = r_tout;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor with hand-computed expectations.
module tb_lfsr_period_monitor;

    localparam int WIDTH      = 4;
    localparam int PERIOD_W   = 8;
    localparam int MAX_PERIOD = 20;

    logic                i_clk;
    logic                i_reset;
    logic                i_restart;
    logic                i_in_valid;
    logic [WIDTH-1:0]    i_in_data;
    logic                o_busy;
    logic                o_period_valid;
    logic [PERIOD_W-1:0] o_period;
    logic                o_zero_err;
    logic                o_stuck_err;
    logic                o_timeout_err;

    int n_vec = 0;
    int n_err = 0;

    lfsr_period_monitor #(
        .WIDTH      (WIDTH),
        .PERIOD_W   (PERIOD_W),
        .MAX_PERIOD (MAX_PERIOD)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_restart      (i_restart),
        .i_in_valid     (i_in_valid),
        .i_in_data      (i_in_data),
        .o_busy         (o_busy),
        .o_period_valid (o_period_valid),
        .o_period       (o_period),
        .o_zero_err     (o_zero_err),
        .o_stuck_err    (o_stuck_err),
        .o_timeout_err  (o_timeout_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // x^4+x^3+1 Fibonacci step
    function automatic logic [3:0] lfsr_nxt(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b, input logic pv,
                           input logic [7:0] per, input logic z, input logic s,
                           input logic t);
        chk(tag, {19'd0, o_busy, o_period_valid, o_period, o_zero_err, o_stuck_err, o_timeout_err},
                 {19'd0, b, pv, per, z, s, t});
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        @(negedge i_clk);
        i_restart  = 1'b0;
        i_in_valid = v;
        i_in_data  = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_restart(input logic v, input logic [3:0] d);
        @(negedge i_clk);
        i_restart  = 1'b1;
        i_in_valid = v;
        i_in_data  = d;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [3:0] s;
        int got;

        i_reset    = 1'b0;
        i_restart  = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        #12;
        chk_out("reset_state", 0, 0, 8'd0, 0, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Maximal LFSR from 0001, continuous valid
        s = 4'h1;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, s);
            s = lfsr_nxt(s);
            if (i == 1)  chk_out("lfsr_first", 1, 0, 8'd0, 0, 0, 0);
            if (i == 15) chk_out("lfsr_15th", 1, 0, 8'd0, 0, 0, 0);
            if (i == 16) chk_out("lfsr_done", 0, 1, 8'd15, 0, 0, 0);
        end
        step(1'b1, 4'h5);
        chk_out("done_hold", 0, 1, 8'd15, 0, 0, 0);
        do_restart(1'b0, 4'h0);
        chk_out("restart_clear1", 0, 0, 8'd0, 0, 0, 0);

        // Same stream with random gaps; zeros on invalid cycles must be ignored
        s = 4'h1;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            if ($urandom_range(0, 99) < 30) begin
                step(1'b0, 4'h0);
            end else begin
                step(1'b1, s);
                s = lfsr_nxt(s);
                got++;
                if (got == 15) chk_out("gap_15th", 1, 0, 8'd0, 0, 0, 0);
                if (got == 16) chk_out("gap_done", 0, 1, 8'd15, 0, 0, 0);
            end
        end
        chk("gap_samples", got, 16);
        do_restart(1'b0, 4'h0);

        // Stuck stream, then zero
        step(1'b1, 4'h3);
        step(1'b1, 4'h9);
        chk_out("stuck_pre", 1, 0, 8'd0, 0, 0, 0);
        step(1'b1, 4'h9);
        chk_out("stuck_err", 0, 0, 8'd0, 0, 1, 0);
        step(1'b1, 4'h3);
        chk_out("stuck_hold", 0, 0, 8'd0, 0, 1, 0);
        do_restart(1'b0, 4'h0);
        chk_out("restart_clear2", 0, 0, 8'd0, 0, 0, 0);
        step(1'b1, 4'h0);
        chk_out("zero_err", 0, 0, 8'd0, 1, 0, 0);
        do_restart(1'b0, 4'h0);

        // Timeout: seed 1 then 2..15 cycling, seed never recurs
        step(1'b1, 4'h1);
        for (int k = 2; k <= 21; k++) begin
            step(1'b1, 4'(((k - 2) % 14) + 2));
            if (k == 20) chk_out("tout_pre", 1, 0, 8'd0, 0, 0, 0);
            if (k == 21) chk_out("tout_err", 0, 0, 8'd0, 0, 0, 1);
        end
        do_restart(1'b0, 4'h0);

        // Async reset after 7 samples
        s = 4'h1;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, s);
            s = lfsr_nxt(s);
        end
        chk_out("mid_busy", 1, 0, 8'd0, 0, 0, 0);
        #2;
        i_reset = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 8'd0, 0, 0, 0);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        s = 4'h8;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, s);
            s = lfsr_nxt(s);
            if (i == 16) chk_out("post_reset_done", 0, 1, 8'd15, 0, 0, 0);
        end

        // restart together with valid in DONE: sample must not be captured
        do_restart(1'b1, 4'h7);
        chk_out("restart_valid", 0, 0, 8'd0, 0, 0, 0);
        step(1'b0, 4'h0);
        chk_out("no_capture", 0, 0, 8'd0, 0, 0, 0);
        s = 4'h6;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, s);
            s = lfsr_nxt(s);
            if (i == 1)  chk_out("new_seed", 1, 0, 8'd0, 0, 0, 0);
            if (i == 15) chk_out("new_15th", 1, 0, 8'd0, 0, 0, 0);
            if (i == 16) chk_out("new_done", 0, 1, 8'd15, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
